// File: rtl/bsg_mem_req_pkg.sv
// +----------------------------------------------------------------------------+
// | bsg_mem_req_pkg                                                            |
// | Shared size encoding and lane helpers for the byte-masked memory requester.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package bsg_mem_req_pkg;

   // Helpers work on the widest supported word; callers cast down to their width.
   localparam int c_max_data_width = 1024;
   localparam int c_max_mask_width = c_max_data_width / 8;
   localparam int c_idx_w          = $clog2(c_max_data_width);

   typedef enum logic [1:0] {
      e_size_byte  = 2'd0,
      e_size_half  = 2'd1,
      e_size_word  = 2'd2,
      e_size_dword = 2'd3
   } size_e;

   function automatic logic [c_max_mask_width-1:0] mask_f(input int unsigned lg_size,
                                                          input int unsigned offset);
      logic [c_max_mask_width-1:0] m;
      m = '0;
      for (int unsigned i = 0; i < c_max_mask_width; i++) begin
         m[i] = (i >= offset) && (i < offset + (32'd1 << lg_size));
      end
      return m;
   endfunction

   function automatic logic [c_max_data_width-1:0] replicate_f(input logic [c_max_data_width-1:0] d,
                                                               input int unsigned lg_size);
      logic [c_max_data_width-1:0] r;
      int unsigned                 nbits;
      nbits = 32'd8 << lg_size;
      r     = '0;
      for (int unsigned i = 0; i < c_max_data_width; i++) begin
         r[i] = d[c_idx_w'(i % nbits)];
      end
      return r;
   endfunction

   function automatic logic [c_max_data_width-1:0] extend_f(input logic [c_max_data_width-1:0] d,
                                                            input int unsigned lg_size,
                                                            input logic sgn);
      logic [c_max_data_width-1:0] r;
      logic [c_idx_w-1:0]          msb;
      int unsigned                 nbits;
      nbits = 32'd8 << lg_size;
      msb   = c_idx_w'(nbits - 32'd1);
      r     = '0;
      for (int unsigned i = 0; i < c_max_data_width; i++) begin
         r[i] = (i < nbits) ? d[i] : (sgn & d[msb]);
      end
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/bsg_two_fifo.sv
// +----------------------------------------------------------------------------+
// | bsg_two_fifo                                                               |
// | Two-entry valid/yumi FIFO; occupancy exported for credit accounting.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module bsg_two_fifo #(
   parameter int width_p = 8
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic               v_i,
   input  logic [width_p-1:0] data_i,
   output logic               v_o,
   output logic [width_p-1:0] data_o,
   input  logic               yumi_i,
   output logic [1:0]         count_o
);

   logic [width_p-1:0] mem0_q, mem0_d;
   logic [width_p-1:0] mem1_q, mem1_d;
   logic               rd_ptr_q, rd_ptr_d;
   logic               wr_ptr_q, wr_ptr_d;
   logic [1:0]         count_q, count_d;

   // Enqueue when full is prevented upstream by the credit check.
   always_comb begin
      mem0_d   = mem0_q;
      mem1_d   = mem1_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      if (v_i) begin
         if (wr_ptr_q) mem1_d = data_i;
         else          mem0_d = data_i;
         wr_ptr_d = ~wr_ptr_q;
      end
      if (yumi_i) rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + {1'b0, v_i} - {1'b0, yumi_i};
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         mem0_q   <= '0;
         mem1_q   <= '0;
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         mem0_q   <= mem0_d;
         mem1_q   <= mem1_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   assign v_o     = (count_q != 2'd0);
   assign data_o  = rd_ptr_q ? mem1_q : mem0_q;
   assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/bsg_mem_1rw_sync_mask_write_byte_requester.sv
// +----------------------------------------------------------------------------+
// | bsg_mem_1rw_sync_mask_write_byte_requester                                 |
// | Sized byte-addressed load/store front end for a 1RW byte-masked memory.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module bsg_mem_1rw_sync_mask_write_byte_requester
   import bsg_mem_req_pkg::*;
#(
   parameter  int els_p              = 512,
   parameter  int data_width_p       = 64,
   localparam int mask_width_lp      = data_width_p >> 3,
   localparam int word_addr_width_lp = $clog2(els_p),
   localparam int lg_bytes_lp        = $clog2(mask_width_lp),
   localparam int byte_addr_width_lp = word_addr_width_lp + lg_bytes_lp,
   localparam int size_width_lp      = $clog2(lg_bytes_lp + 1)
) (
   input  logic                          clk_i,
   input  logic                          reset_n_i,
   input  logic                          v_i,
   output logic                          ready_o,
   input  logic                          w_i,
   input  logic [byte_addr_width_lp-1:0] addr_i,
   input  logic [size_width_lp-1:0]      size_i,
   input  logic                          signed_i,
   input  logic [data_width_p-1:0]       data_i,
   output logic                          mem_v_o,
   output logic                          mem_w_o,
   output logic [word_addr_width_lp-1:0] mem_addr_o,
   output logic [data_width_p-1:0]       mem_data_o,
   output logic [mask_width_lp-1:0]      mem_w_mask_o,
   input  logic [data_width_p-1:0]       mem_data_i,
   output logic                          v_o,
   output logic [data_width_p-1:0]       data_o,
   output logic                          err_o,
   input  logic                          yumi_i,
   output logic                          misalign_o
);

   typedef struct packed {
      logic                    err;
      logic [data_width_p-1:0] data;
   } resp_s;

   logic [lg_bytes_lp-1:0]   w_off;
   logic [size_width_lp-1:0] w_size_cl;
   logic                     w_size_ok, w_aligned, w_fire, w_deq;
   logic [1:0]               w_count;
   logic [2:0]               w_credits;
   resp_s                    w_enq_resp, w_deq_resp;

   logic                     pend_q, pend_d;
   logic [lg_bytes_lp-1:0]   pend_off_q, pend_off_d;
   logic [size_width_lp-1:0] pend_size_q, pend_size_d;
   logic                     pend_signed_q, pend_signed_d;
   logic                     pend_err_q, pend_err_d;
   logic                     misalign_q, misalign_d;

   // Request side: alignment, credits and lane-aligned memory command.
   always_comb begin
      w_off     = addr_i[lg_bytes_lp-1:0];
      w_size_ok = (32'(size_i) <= 32'(lg_bytes_lp));
      w_size_cl = w_size_ok ? size_i : size_width_lp'(lg_bytes_lp);
      w_aligned = w_size_ok && ((w_off & lg_bytes_lp'((32'd1 << w_size_cl) - 32'd1)) == '0);

      w_deq     = v_o & yumi_i;
      w_credits = 3'(w_count) - 3'(w_deq) + 3'(pend_q);
      ready_o   = reset_n_i & (w_credits < 3'd2);
      w_fire    = v_i & ready_o;

      mem_v_o      = w_fire & w_aligned;
      mem_w_o      = mem_v_o & w_i;
      mem_addr_o   = w_fire ? addr_i[byte_addr_width_lp-1:lg_bytes_lp] : '0;
      mem_data_o   = w_fire ? data_width_p'(replicate_f(c_max_data_width'(data_i), 32'(w_size_cl))) : '0;
      mem_w_mask_o = mem_w_o ? mask_width_lp'(mask_f(32'(w_size_cl), 32'(w_off))) : '0;
   end

   always_comb begin
      pend_d        = w_fire & ~w_i;
      pend_off_d    = pend_off_q;
      pend_size_d   = pend_size_q;
      pend_signed_d = pend_signed_q;
      pend_err_d    = pend_err_q;
      if (w_fire & ~w_i) begin
         pend_off_d    = w_off;
         pend_size_d   = w_size_cl;
         pend_signed_d = signed_i;
         pend_err_d    = ~w_aligned;
      end
      misalign_d = misalign_q | (w_fire & ~w_aligned);
   end

   // Read data arrives the cycle after the access; extract the field as it lands.
   always_comb begin
      w_enq_resp.err  = pend_err_q;
      w_enq_resp.data = pend_err_q ? '0
                      : data_width_p'(extend_f(c_max_data_width'(mem_data_i >> {pend_off_q, 3'b000}),
                                               32'(pend_size_q), pend_signed_q));
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         pend_q        <= 1'b0;
         pend_off_q    <= '0;
         pend_size_q   <= '0;
         pend_signed_q <= 1'b0;
         pend_err_q    <= 1'b0;
         misalign_q    <= 1'b0;
      end else begin
         pend_q        <= pend_d;
         pend_off_q    <= pend_off_d;
         pend_size_q   <= pend_size_d;
         pend_signed_q <= pend_signed_d;
         pend_err_q    <= pend_err_d;
         misalign_q    <= misalign_d;
      end
   end

   bsg_two_fifo #(
      .width_p ($bits(resp_s))
   ) u_resp_fifo (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .v_i       (pend_q),
      .data_i    (w_enq_resp),
      .v_o       (v_o),
      .data_o    (w_deq_resp),
      .yumi_i    (w_deq),
      .count_o   (w_count)
   );

   assign data_o     = w_deq_resp.data;
   assign err_o      = w_deq_resp.err;
   assign misalign_o = misalign_q;

   a_yumi_needs_valid : assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o);

endmodule

`default_nettype wire
